// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder and the MEM/WB path.
package dmem_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    // Access size: number of bytes is 1 << size
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of bytes touched by an access of the given size (1..8)
    function automatic logic [3:0] size_bytes(input size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a little-endian load to 64 bits; purely combinational.
module load_extend
    import dmem_pkg::*;
(
    input  size_e              size,
    input  logic               is_signed,
    input  logic [DATA_W-1:0]  raw,
    output logic [DATA_W-1:0]  ext_data_c
);

    // Select the low bytes of raw and fill the upper bits with sign or zero
    always_comb begin
        ext_data_c = raw;
        case (size)
            SZ_B:    ext_data_c = is_signed ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            SZ_H:    ext_data_c = is_signed ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            SZ_W:    ext_data_c = is_signed ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: ext_data_c = raw;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY edges, commits, pulses resp_valid.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_err
);

    localparam int unsigned AW  = $clog2(DEPTH_BYTES);
    localparam int unsigned AW1 = AW + 1;
    localparam int unsigned CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Reject parameter values the datapath cannot support
    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be at least 1");
    end
    if (DEPTH_BYTES < 8) begin : g_bad_depth
        $error("dmem_responder: DEPTH_BYTES must be at least 8");
    end

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               write_q;
    size_e              size_q;
    logic               signed_q;
    logic [AW-1:0]      addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               err_q;

    logic [7:0]         mem [0:DEPTH_BYTES-1];

    logic               accept_c;
    logic               commit_c;
    logic [3:0]         req_nbytes_c;
    logic               misalign_c;
    logic [ADDR_W:0]    req_end_c;
    logic               req_err_c;
    logic [3:0]         nbytes_q;
    logic [DATA_W-1:0]  raw_c;
    logic [DATA_W-1:0]  ext_c;

    assign accept_c = (state_q == ST_IDLE) && req_valid;
    assign commit_c = (state_q == ST_WAIT) && (cnt_q == '0);

    // Error check on the incoming request; end address kept 65 bits wide so it cannot wrap
    assign req_nbytes_c = size_bytes(size_e'(req_size));
    assign misalign_c   = (req_addr & ADDR_W'(req_nbytes_c - 4'd1)) != '0;
    assign req_end_c    = {1'b0, req_addr} + (ADDR_W + 1)'(req_nbytes_c);
    assign req_err_c    = misalign_c || (req_end_c > (ADDR_W + 1)'(DEPTH_BYTES));

    assign nbytes_q = size_bytes(size_q);

    // State and wait counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> WAIT on accept, count down, one RESP cycle, back to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request on accept; the core holds it but we do not rely on that
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            size_q   <= SZ_B;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept_c) begin
            write_q  <= req_write;
            size_q   <= size_e'(req_size);
            signed_q <= req_signed;
            addr_q   <= req_addr[AW-1:0];
            wdata_q  <= req_wdata;
            err_q    <= req_err_c;
        end
    end

    // Gather the addressed bytes little-endian; lanes past the access size read as zero
    always_comb begin
        raw_c = '0;
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) < nbytes_q) && ((32'(addr_q) + 32'(i)) < DEPTH_BYTES)) begin
                raw_c[8*i +: 8] = mem[AW'(32'(addr_q) + 32'(i))];
            end
        end
    end

    load_extend u_load_extend (
        .size       (size_q),
        .is_signed  (signed_q),
        .raw        (raw_c),
        .ext_data_c (ext_c)
    );

    // One register per array byte; a store writes the lane whose offset falls in the access
    for (genvar b = 0; b < DEPTH_BYTES; b++) begin : g_byte
        logic [AW1-1:0] off_c;
        logic           we_c;

        assign off_c = AW1'(b) - {1'b0, addr_q};
        assign we_c  = commit_c && write_q && !err_q
                       && (AW1'(b) >= {1'b0, addr_q})
                       && (off_c < AW1'(nbytes_q));

        // Byte storage, cleared by reset so an aborted store never lands
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mem[b] <= 8'd0;
            end else if (we_c) begin
                mem[b] <= wdata_q[{off_c[2:0], 3'b000} +: 8];
            end
        end
    end

    // Registered handshake and response; data/err held until the next commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            req_ready  <= (state_d == ST_IDLE);
            resp_valid <= (state_d == ST_RESP);
            if (commit_c) begin
                resp_err   <= err_q;
                resp_rdata <= (write_q || err_q) ? '0 : ext_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, random traffic vs. byte-array model, timing corners.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;

    logic clk;
    logic reset;

    logic        a_req_valid, a_req_ready, a_req_write, a_req_signed;
    logic [1:0]  a_req_size;
    logic [63:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_err;
    logic [63:0] a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_signed;
    logic [1:0]  b_req_size;
    logic [63:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_err;
    logic [63:0] b_resp_rdata;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err)
    );

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain byte array plus arithmetic on the access rules
    logic [7:0] mdl [DEPTH];

    function automatic void mdl_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'd0;
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [63:0] addr);
        logic [64:0] n;
        logic [64:0] last;
        n    = 65'd1 << sz;
        last = {1'b0, addr} + n;
        return ((addr % n[63:0]) != 64'd0) || (last > 65'(DEPTH));
    endfunction

    function automatic logic [63:0] model_load(input logic [1:0] sz, input logic sgn,
                                               input logic [63:0] addr);
        logic [63:0] v;
        int n;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(mdl[int'(addr) + i]) << (8 * i));
        if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [63:0] addr,
                                        input logic [63:0] wdata);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) mdl[int'(addr) + i] = wdata[8*i +: 8];
    endfunction

    // One transaction on the LATENCY=2 instance; lat = edges from accept to resp_valid
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sgn,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rd, output logic er, output int lat,
                          output logic after);
        int k;
        @(negedge clk);
        a_req_write  = w;
        a_req_size   = sz;
        a_req_signed = sgn;
        a_req_addr   = addr;
        a_req_wdata  = wdata;
        a_req_valid  = 1'b1;
        k = 0;
        while (!a_req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        lat = -1;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk);
            #1;
            if (a_resp_valid) begin
                lat = j;
                break;
            end
        end
        rd = a_resp_rdata;
        er = a_resp_err;
        @(posedge clk);
        #1 after = a_resp_valid;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    logic [63:0] rd;
    logic        er, after;
    int          lat;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 2'd3, 1'b0, 64'd0,  64'd0,                  64'd0,                  1'b0};
        vecs[1]  = '{1'b1, 2'd3, 1'b0, 64'd8,  64'h8877665544332211,   64'd0,                  1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 64'd15, 64'd0,                  64'hFFFFFFFFFFFFFF88,   1'b0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 64'd12, 64'd0,                  64'h0000000088776655,   1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 64'd9,  64'd0,                  64'd0,                  1'b1};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 64'd64, 64'hCAFEF00DCAFEF00D,   64'd0,                  1'b1};
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 64'd56, 64'd0,                  64'd0,                  1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 64'd8,  64'd0,                  64'h0000000000002211,   1'b0};
        vecs[8]  = '{1'b0, 2'd3, 1'b1, 64'd8,  64'd0,                  64'h8877665544332211,   1'b0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 64'd60, 64'hDEADBEEF80000001,   64'd0,                  1'b0};
        vecs[10] = '{1'b0, 2'd2, 1'b1, 64'd60, 64'd0,                  64'hFFFFFFFF80000001,   1'b0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 64'd63, 64'd0,                  64'h0000000000000080,   1'b0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0,    64'd0,                  1'b1};

        a_req_valid = 0; a_req_write = 0; a_req_size = 0; a_req_signed = 0;
        a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_write = 0; b_req_size = 0; b_req_signed = 0;
        b_req_addr = 0; b_req_wdata = 0;
        mdl_clear();

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset req_ready",  64'(a_req_ready),  64'd1);
        chk("reset resp_valid", 64'(a_resp_valid), 64'd0);
        chk("reset resp_rdata", a_resp_rdata,      64'd0);
        chk("reset resp_err",   64'(a_resp_err),   64'd0);
        chk("reset l1 req_ready", 64'(b_req_ready), 64'd1);

        // Directed table on the LATENCY=2 instance
        for (int i = 0; i < 13; i++) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, after);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d err", i), 64'(er), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
            chk($sformatf("vec%0d pulse width", i), 64'(after), 64'd0);
            if (vecs[i].w && !vecs[i].exp_err) model_store(vecs[i].sz, vecs[i].addr, vecs[i].wdata);
        end

        // Random traffic against the byte-array model
        for (int i = 0; i < 60; i++) begin
            logic        w, sgn, exp_err;
            logic [1:0]  sz;
            logic [63:0] addr, wdata, exp_rd;
            w     = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 3));
            wdata = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) addr = {$urandom, $urandom};
            else addr = 64'($urandom_range(0, 71));
            if ($urandom_range(0, 2) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            exp_err = model_err(sz, addr);
            exp_rd  = (w || exp_err) ? 64'd0 : model_load(sz, sgn, addr);
            do_req(w, sz, sgn, addr, wdata, rd, er, lat, after);
            chk($sformatf("rand%0d rdata", i), rd, exp_rd);
            chk($sformatf("rand%0d err", i), 64'(er), 64'(exp_err));
            chk($sformatf("rand%0d latency", i), 64'(lat), 64'd2);
            if (w && !exp_err) model_store(sz, addr, wdata);
        end

        // req_valid held for 12 cycles on both instances: accepts every LATENCY+2 cycles
        begin
            int acc_a[$], rsp_a[$], acc_b[$], rsp_b[$];
            int low_a;
            low_a = 0;
            @(negedge clk);
            a_req_write = 0; a_req_size = 2'd3; a_req_signed = 0; a_req_addr = 0;
            b_req_write = 0; b_req_size = 2'd3; b_req_signed = 0; b_req_addr = 0;
            a_req_valid = 1'b1;
            b_req_valid = 1'b1;
            for (int c = 0; c < 12; c++) begin
                if (c > 0) @(negedge clk);
                if (a_req_ready) acc_a.push_back(c); else low_a++;
                if (a_resp_valid) rsp_a.push_back(c);
                if (b_req_ready) acc_b.push_back(c);
                if (b_resp_valid) rsp_b.push_back(c);
            end
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
            chk("held accepts", 64'(acc_a.size()), 64'd3);
            chk("held responses", 64'(rsp_a.size()), 64'd3);
            chk("held ready low cycles", 64'(low_a), 64'd9);
            for (int i = 0; i < acc_a.size() && i < rsp_a.size(); i++) begin
                chk($sformatf("held accept%0d cycle", i), 64'(acc_a[i]), 64'(4 * i));
                chk($sformatf("held resp%0d cycle", i), 64'(rsp_a[i]), 64'(4 * i + 3));
            end
            chk("l1 held accepts", 64'(acc_b.size()), 64'd4);
            chk("l1 held responses", 64'(rsp_b.size()), 64'd4);
            for (int i = 0; i < acc_b.size() && i < rsp_b.size(); i++) begin
                chk($sformatf("l1 accept%0d cycle", i), 64'(acc_b[i]), 64'(3 * i));
                chk($sformatf("l1 resp%0d cycle", i), 64'(rsp_b[i]), 64'(3 * i + 2));
            end
        end
        repeat (3) @(negedge clk);

        // Store to addr 0 aborted by reset during WAIT: no pulse, array cleared
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            a_req_write = 1'b1; a_req_size = 2'd3; a_req_signed = 0;
            a_req_addr = 64'd0; a_req_wdata = ~64'd0; a_req_valid = 1'b1;
            @(posedge clk);
            #1 a_req_valid = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            mdl_clear();
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (a_resp_valid) pulses++;
            end
            chk("abort no resp pulse", 64'(pulses), 64'd0);
            chk("abort req_ready", 64'(a_req_ready), 64'd1);
            chk("abort resp_rdata cleared", a_resp_rdata, 64'd0);
            do_req(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, rd, er, lat, after);
            chk("abort load addr0", rd, model_load(2'd3, 1'b0, 64'd0));
            chk("abort load addr0 err", 64'(er), 64'd0);
            do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, rd, er, lat, after);
            chk("reset cleared addr8", rd, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
